// File: rtl/ir_packet_if.sv
// Bundle of the IR receiver pin and decoded-packet status signals.
// master: the decoder (reads ir_in, drives status).
// slave:  the board side (drives ir_in, reads status).
// The filter_car input exists only when IR_CAR_FILTER_EN is defined.
interface ir_packet_if;
   logic       ir_in;
`ifdef IR_CAR_FILTER_EN
   logic [1:0] filter_car;
`endif
   logic [1:0] car_id;
   logic [3:0] command;
   logic       packet_valid;
   logic       packet_err;
   logic       busy;

   modport master (
      input  ir_in,
`ifdef IR_CAR_FILTER_EN
      input  filter_car,
`endif
      output car_id,
      output command,
      output packet_valid,
      output packet_err,
      output busy
   );

   modport slave (
      output ir_in,
`ifdef IR_CAR_FILTER_EN
      output filter_car,
`endif
      input  car_id,
      input  command,
      input  packet_valid,
      input  packet_err,
      input  busy
   );
endinterface

// File: rtl/ir_packet_decoder.sv
// IR packet decoder: measures carrier bursts as rising-edge counts and walks
// START, car-select and four command bursts (right, left, backward, forward).
// Optional macro IR_CAR_FILTER_EN: packets whose car index differs from
// bus.filter_car are dropped silently.
//
// state   | meaning
// S_IDLE  | waiting for the first carrier edge
// S_START | measuring the START burst
// S_SEL   | measuring the car-select burst
// S_CMD   | measuring command burst idx_q (0=right .. 3=forward)
// S_DONE  | one-cycle packet completion, returns to idle
module ir_packet_decoder #(
   parameter int GAP_CYCLES    = 5000,
   parameter int FRAME_TIMEOUT = 200000,
   parameter int START_MIN     = 80,
   parameter int START_MAX     = 200,
   parameter int SEL_LEN_0     = 47,
   parameter int SEL_LEN_1     = 22,
   parameter int SEL_LEN_2     = 44,
   parameter int SEL_LEN_3     = 24,
   parameter int SEL_TOL       = 1,
   parameter int CMD_MIN       = 16,
   parameter int CMD_MAX       = 60,
   parameter int ASSERT_MIN    = 36
) (
   input  logic          clk,
   input  logic          reset,
   ir_packet_if.master   bus
);

   localparam int GAP_W = $clog2(GAP_CYCLES + 1);
   localparam int FT_W  = $clog2(FRAME_TIMEOUT + 1);
   localparam int SEL_LEN [4] = '{SEL_LEN_0, SEL_LEN_1, SEL_LEN_2, SEL_LEN_3};

   typedef enum logic [2:0] {S_IDLE, S_START, S_SEL, S_CMD, S_DONE} state_t;

   state_t           state_q, state_d;
   logic             ir_s1_q, ir_s1_d, ir_s2_q, ir_s2_d, ir_s3_q, ir_s3_d;
   logic [7:0]       edge_cnt_q, edge_cnt_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [FT_W-1:0]  frame_cnt_q, frame_cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [1:0]       car_tmp_q, car_tmp_d;
   logic [3:0]       cmd_tmp_q, cmd_tmp_d;
   logic [1:0]       car_id_q, car_id_d;
   logic [3:0]       command_q, command_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;

   logic             edge_det, burst_end, timeout, accept, sel_hit, cmd_bit;
   logic [1:0]       sel_car;
   int               n_i;

   // Next-state logic: edge/gap measurement, frame timer and packet walk.
   always_comb begin
      ir_s1_d     = bus.ir_in;
      ir_s2_d     = ir_s1_q;
      ir_s3_d     = ir_s2_q;
      edge_det    = ir_s2_q & ~ir_s3_q;
      burst_end   = (gap_cnt_q == '0) && (edge_cnt_q != 8'd0);
      n_i         = int'({24'd0, edge_cnt_q});
      timeout     = ((state_q == S_SEL) || (state_q == S_CMD)) && (frame_cnt_q == '0);
      cmd_bit     = (n_i >= ASSERT_MIN);

      // Scan downwards so the lowest matching car index wins.
      sel_hit = 1'b0;
      sel_car = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if ((n_i >= SEL_LEN[k] - SEL_TOL) && (n_i <= SEL_LEN[k] + SEL_TOL)) begin
            sel_hit = 1'b1;
            sel_car = 2'(k);
         end
      end

`ifdef IR_CAR_FILTER_EN
      accept = (car_tmp_q == bus.filter_car);
`else
      accept = 1'b1;
`endif

      gap_cnt_d = edge_det ? GAP_W'(GAP_CYCLES)
                : (gap_cnt_q == '0) ? '0 : gap_cnt_q - GAP_W'(1);

      // An edge coinciding with burst end starts the next burst.
      if (burst_end)
         edge_cnt_d = edge_det ? 8'd1 : 8'd0;
      else if (edge_det && (edge_cnt_q != 8'hFF))
         edge_cnt_d = edge_cnt_q + 8'd1;
      else
         edge_cnt_d = edge_cnt_q;

      // Frame timer only runs between bursts of an open packet.
      if (edge_det || !((state_q == S_SEL) || (state_q == S_CMD)))
         frame_cnt_d = FT_W'(FRAME_TIMEOUT);
      else if (frame_cnt_q != '0)
         frame_cnt_d = frame_cnt_q - FT_W'(1);
      else
         frame_cnt_d = frame_cnt_q;

      state_d   = state_q;
      idx_d     = idx_q;
      car_tmp_d = car_tmp_q;
      cmd_tmp_d = cmd_tmp_q;
      car_id_d  = car_id_q;
      command_d = command_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (edge_det || (edge_cnt_q != 8'd0))
               state_d = S_START;
         end
         S_START: begin
            if (burst_end) begin
               if ((n_i >= START_MIN) && (n_i <= START_MAX)) begin
                  state_d = S_SEL;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         S_SEL: begin
            if (burst_end) begin
               if (sel_hit) begin
                  car_tmp_d = sel_car;
                  cmd_tmp_d = 4'd0;
                  idx_d     = 2'd0;
                  state_d   = S_CMD;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end else if (timeout) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_CMD: begin
            if (burst_end) begin
               if ((n_i < CMD_MIN) || (n_i > CMD_MAX)) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  cmd_tmp_d[idx_q] = cmd_bit;
                  if (idx_q == 2'd3) begin
                     // Outputs load here so they and the pulse appear in the DONE cycle.
                     if (accept) begin
                        car_id_d  = car_tmp_q;
                        command_d = {cmd_bit, cmd_tmp_q[2:0]};
                        valid_d   = 1'b1;
                     end
                     state_d = S_DONE;
                  end else begin
                     idx_d = idx_q + 2'd1;
                  end
               end
            end else if (timeout) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         ir_s1_q     <= 1'b0;
         ir_s2_q     <= 1'b0;
         ir_s3_q     <= 1'b0;
         edge_cnt_q  <= 8'd0;
         gap_cnt_q   <= '0;
         frame_cnt_q <= '0;
         idx_q       <= 2'd0;
         car_tmp_q   <= 2'd0;
         cmd_tmp_q   <= 4'd0;
         car_id_q    <= 2'd0;
         command_q   <= 4'd0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ir_s1_q     <= ir_s1_d;
         ir_s2_q     <= ir_s2_d;
         ir_s3_q     <= ir_s3_d;
         edge_cnt_q  <= edge_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         idx_q       <= idx_d;
         car_tmp_q   <= car_tmp_d;
         cmd_tmp_q   <= cmd_tmp_d;
         car_id_q    <= car_id_d;
         command_q   <= command_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
      end
   end

   assign bus.car_id       = car_id_q;
   assign bus.command      = command_q;
   assign bus.packet_valid = valid_q;
   assign bus.packet_err   = err_q;
   assign bus.busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_ir_packet_decoder.sv
// Directed bench for ir_packet_decoder with shortened gap/timeout parameters.
// Carrier is modelled as a square wave of 'half' clocks high/low per edge.
module tb_ir_packet_decoder;

   localparam int GAP = 24;
   localparam int FTO = 300;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_chk = 0;
   int   n_bad = 0;
   int   valid_cnt = 0;
   int   valid_hi = 0;
   int   err_cnt = 0;
   int   both_cnt = 0;
   int   v0, e0;

   ir_packet_if bus();

   ir_packet_decoder #(
      .GAP_CYCLES    (GAP),
      .FRAME_TIMEOUT (FTO)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   // Pulse monitor, sampled away from the active edge.
   always @(negedge clk) begin
      if (bus.packet_valid) valid_hi++;
      if (bus.packet_err) err_cnt++;
      if (bus.packet_valid && bus.packet_err) both_cnt++;
   end

   logic valid_prev = 1'b0;
   always @(negedge clk) begin
      if (bus.packet_valid && !valid_prev) valid_cnt++;
      valid_prev <= bus.packet_valid;
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic set_filter(input int car);
`ifdef IR_CAR_FILTER_EN
      bus.filter_car = 2'(car);
`else
      if (car < 0) $display("note: negative car index %0d", car);
`endif
   endtask

   task automatic send_burst(input int n, input int half, input int sil);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); bus.ir_in = 1'b1;
         repeat (half) @(posedge clk);
         bus.ir_in = 1'b0;
         repeat (half - 1) @(posedge clk);
      end
      repeat (sil) @(posedge clk);
   endtask

   task automatic send_packet(input int b0, input int b1, input int b2,
                              input int b3, input int b4, input int b5,
                              input int half);
      int sil;
      sil = 25 * 2 * half;
      send_burst(b0, half, sil);
      send_burst(b1, half, sil);
      send_burst(b2, half, sil);
      send_burst(b3, half, sil);
      send_burst(b4, half, sil);
      send_burst(b5, half, sil);
   endtask

   task automatic mark();
      v0 = valid_cnt;
      e0 = err_cnt;
   endtask

   initial begin
      bus.ir_in = 1'b0;
      set_filter(0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("rst_car_id", int'(bus.car_id), 0);
      chk("rst_command", int'(bus.command), 0);
      chk("rst_valid", int'(bus.packet_valid), 0);
      chk("rst_err", int'(bus.packet_err), 0);
      chk("rst_busy", int'(bus.busy), 0);
      @(posedge clk); reset = 1'b0;
      repeat (5) @(posedge clk);

      // Blue packet at the slower carrier
      mark(); set_filter(0);
      send_packet(191, 47, 48, 22, 22, 48, 3);
      @(negedge clk);
      chk("blue_valid", valid_cnt - v0, 1);
      chk("blue_err", err_cnt - e0, 0);
      chk("blue_car", int'(bus.car_id), 0);
      chk("blue_cmd", int'(bus.command), 4'b1001);
      chk("blue_busy", int'(bus.busy), 0);

      // Yellow then red
      mark(); set_filter(1);
      send_packet(88, 22, 22, 48, 22, 22, 2);
      @(negedge clk);
      chk("yellow_valid", valid_cnt - v0, 1);
      chk("yellow_car", int'(bus.car_id), 1);
      chk("yellow_cmd", int'(bus.command), 4'b0010);
      mark(); set_filter(3);
      send_packet(88, 24, 48, 48, 48, 48, 2);
      @(negedge clk);
      chk("red_valid", valid_cnt - v0, 1);
      chk("red_car", int'(bus.car_id), 3);
      chk("red_cmd", int'(bus.command), 4'b1111);

      // Boundaries: START_MIN, select 46 matches car 0 first, 35/36/60/16 commands
      mark(); set_filter(0);
      send_packet(80, 46, 35, 36, 60, 16, 2);
      @(negedge clk);
      chk("bnd_valid", valid_cnt - v0, 1);
      chk("bnd_car", int'(bus.car_id), 0);
      chk("bnd_cmd", int'(bus.command), 4'b0110);

      // START of 50: every following burst is also too short for START
      mark();
      send_packet(50, 47, 48, 22, 22, 48, 2);
      @(negedge clk);
      chk("bad_start_err", err_cnt - e0, 6);
      chk("bad_start_valid", valid_cnt - v0, 0);
      chk("bad_start_cmd", int'(bus.command), 4'b0110);

      // Bad select, then bad command length, then a good green packet
      mark();
      send_burst(88, 2, 100);
      send_burst(35, 2, 100);
      send_burst(88, 2, 100);
      send_burst(47, 2, 100);
      send_burst(70, 2, 100);
      @(negedge clk);
      chk("bad_sel_cmd_err", err_cnt - e0, 2);
      chk("bad_sel_cmd_valid", valid_cnt - v0, 0);
      mark(); set_filter(2);
      send_packet(200, 44, 60, 36, 16, 16, 2);
      @(negedge clk);
      chk("green_valid", valid_cnt - v0, 1);
      chk("green_car", int'(bus.car_id), 2);
      chk("green_cmd", int'(bus.command), 4'b0011);

      // Edge counter saturates at 255, above START_MAX
      mark();
      send_burst(300, 2, 100);
      @(negedge clk);
      chk("sat_err", err_cnt - e0, 1);

      // Frame timeout after two command bursts
      mark();
      send_burst(88, 2, 100);
      send_burst(22, 2, 100);
      send_burst(48, 2, 100);
      send_burst(48, 2, 100);
      repeat (FTO + 10) @(posedge clk);
      @(negedge clk);
      chk("tmo_err", err_cnt - e0, 1);
      chk("tmo_valid", valid_cnt - v0, 0);
      chk("tmo_busy", int'(bus.busy), 0);
      chk("tmo_car_hold", int'(bus.car_id), 2);

      // Reset in the middle of a packet
      mark();
      send_burst(88, 2, 100);
      send_burst(22, 2, 100);
      send_burst(20, 2, 0);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("mid_rst_car", int'(bus.car_id), 0);
      chk("mid_rst_cmd", int'(bus.command), 0);
      chk("mid_rst_busy", int'(bus.busy), 0);
      @(posedge clk); reset = 1'b0;
      repeat (FTO + 50) @(posedge clk);
      @(negedge clk);
      chk("mid_rst_err", err_cnt - e0, 0);
      chk("mid_rst_valid", valid_cnt - v0, 0);
      chk("mid_rst_busy2", int'(bus.busy), 0);

`ifdef IR_CAR_FILTER_EN
      // Only the filtered car produces a packet
      mark(); set_filter(2);
      send_packet(191, 47, 48, 22, 22, 48, 2);
      @(negedge clk);
      chk("filt_blue_valid", valid_cnt - v0, 0);
      chk("filt_blue_err", err_cnt - e0, 0);
      chk("filt_blue_car", int'(bus.car_id), 0);
      send_packet(88, 44, 48, 22, 22, 48, 2);
      @(negedge clk);
      chk("filt_green_valid", valid_cnt - v0, 1);
      chk("filt_green_car", int'(bus.car_id), 2);
      chk("filt_green_cmd", int'(bus.command), 4'b1001);
`endif

      chk("no_simultaneous_pulses", both_cnt, 0);
      chk("valid_one_cycle", valid_hi, valid_cnt);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
